// File: rtl/dmem_pkg.sv
// Shared constants for the data-bus responder: default address map, MMIO
// register offsets, STATUS bit positions and the load FSM encoding.
package dmem_pkg;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_CYCLES = 32'h0000_0008;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_DONE = 1'b1
    } rd_state_e;

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// Synchronous byte FIFO for the TX console path. Pointers carry one extra
// wrap bit so full and empty can be told apart when the indices match.
module tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] store [FIFO_DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A simultaneous pop frees the head slot, so a push into a full FIFO is kept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr[AW-1:0]] <= din;
                wr_ptr                <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign dout = store[rd_ptr[AW-1:0]];

endmodule

// File: rtl/data_mem_responder.sv
// Data-bus responder for the MEM stage: byte-enabled data RAM with one load
// wait state, plus an MMIO page holding the TX FIFO, its status and a cycle counter.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter logic [31:0] DATA_BASE  = DATA_BASE_DEFAULT,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iMemAddress,
    input  logic [31:0] iMemWriteData,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [3:0]  iByteEnable,
    output logic [31:0] oMemReadData,
    output logic        oLock,
    output logic        oBusError,
    output logic [7:0]  oTxData,
    output logic        oTxValid,
    input  logic        iTxReady
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    rd_state_e   state;
    rd_state_e   state_next;
    logic [31:0] ram_off;
    logic [AW-1:0] ram_idx;
    logic        ram_hit;
    logic        tx_hit;
    logic        status_hit;
    logic        cycles_hit;
    logic        mapped;
    logic        load;
    logic        store;
    logic        rd_start;
    logic [31:0] rd_q;
    logic [31:0] ram [RAM_WORDS];
    logic [31:0] cycles;
    logic [31:0] status_word;
    logic        overflow;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    // Address decode; MMIO registers match only their exact word address.
    assign ram_off    = iMemAddress - DATA_BASE;
    assign ram_hit    = (iMemAddress >= DATA_BASE) && (ram_off < RAM_BYTES);
    assign ram_idx    = ram_off[AW+1:2];
    assign tx_hit     = (iMemAddress == MMIO_BASE + OFF_TXDATA);
    assign status_hit = (iMemAddress == MMIO_BASE + OFF_STATUS);
    assign cycles_hit = (iMemAddress == MMIO_BASE + OFF_CYCLES);
    assign mapped     = ram_hit || tx_hit || status_hit || cycles_hit;

    // A request with both strobes high behaves as a store that also flags an error.
    assign store     = iMemWrite;
    assign load      = iMemRead && !iMemWrite;
    assign oBusError = (iMemRead || iMemWrite) && (!mapped || (iMemRead && iMemWrite));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load && ram_hit) state_next = RD_DONE;
            RD_DONE: state_next = IDLE;
        endcase
    end

    always_comb begin
        oLock    = 1'b0;
        rd_start = 1'b0;
        case (state)
            IDLE: begin
                oLock    = load && ram_hit;
                rd_start = load && ram_hit;
            end
            RD_DONE: begin
                oLock    = 1'b0;
                rd_start = 1'b0;
            end
        endcase
    end

    // Stores commit at this edge, before any later registered read of the same word.
    always_ff @(posedge iCLK) begin
        if (store && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (iByteEnable[i]) begin
                    ram[ram_idx][8*i +: 8] <= iMemWriteData[8*i +: 8];
                end
            end
        end
        if (rd_start) begin
            rd_q <= ram[ram_idx];
        end
    end

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_OVF_BIT]   = overflow;
    end

    always_comb begin
        oMemReadData = '0;
        if (state == RD_DONE) begin
            oMemReadData = rd_q;
        end else if (load && status_hit) begin
            oMemReadData = status_word;
        end else if (load && cycles_hit) begin
            oMemReadData = cycles;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cycles <= '0;
        end else if (store && cycles_hit) begin
            cycles <= iMemWriteData;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // TX handshake: a byte leaves the FIFO on every edge where oTxValid && iTxReady;
    // oTxData is stable while oTxValid is high and iTxReady is low.
    assign fifo_push = store && tx_hit;
    assign fifo_pop  = oTxValid && iTxReady;
    assign oTxValid  = !fifo_empty;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            overflow <= 1'b0;
        end else if (store && status_hit) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_tx_fifo (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (iMemWriteData[7:0]),
        .dout  (oTxData),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder: a queue/array reference
// model predicts each bus response and the TX byte stream.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] DBASE      = 32'h1001_0000;
    localparam logic [31:0] MBASE      = 32'hFFFF_0000;
    localparam int          RAM_WORDS  = 1024;
    localparam int          FIFO_DEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        berr;
        logic [1:0]  waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [3:0]  byte_en = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] rdata;
    logic        lock;
    logic        berr;
    logic [7:0]  tx_data;
    logic        tx_valid;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit tx_mon_en = 1'b0;
    int mon_waits = 0;

    exp_t        exp_q[$];
    logic [7:0]  fifo_m[$];
    logic [31:0] mem_m [RAM_WORDS];
    bit          ovf_m = 1'b0;
    logic [31:0] cyc_base = '0;
    logic [31:0] cyc_edge = '0;
    logic [31:0] edge_cnt = '0;

    data_mem_responder dut (
        .iCLK          (clk),
        .iRST          (rst),
        .iMemAddress   (mem_addr),
        .iMemWriteData (mem_wdata),
        .iMemRead      (mem_read),
        .iMemWrite     (mem_write),
        .iByteEnable   (byte_en),
        .oMemReadData  (rdata),
        .oLock         (lock),
        .oBusError     (berr),
        .oTxData       (tx_data),
        .oTxValid      (tx_valid),
        .iTxReady      (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic bit in_ram(input logic [31:0] a);
        return (a >= DBASE) && (a < DBASE + 32'(4 * RAM_WORDS));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - DBASE) >> 2);
    endfunction

    function automatic exp_t model_expect(input bit rd, input bit wr, input logic [31:0] a);
        exp_t e;
        bit   ram;
        bit   mapped;
        ram    = in_ram(a);
        mapped = ram || (a == MBASE) || (a == MBASE + 32'h4) || (a == MBASE + 32'h8);
        e.addr  = a;
        e.rdata = '0;
        e.waits = 2'd0;
        e.berr  = (rd || wr) && (!mapped || (rd && wr));
        if (rd && !wr) begin
            if (ram) begin
                e.rdata = mem_m[widx(a)];
                e.waits = 2'd1;
            end else if (a == MBASE + 32'h4) begin
                e.rdata = {29'b0, ovf_m, fifo_m.size() == FIFO_DEPTH, fifo_m.size() == 0};
            end else if (a == MBASE + 32'h8) begin
                e.rdata = cyc_base + (edge_cnt - cyc_edge);
            end
        end
        return e;
    endfunction

    // Reference model: state advances on each rising edge from the bench-driven inputs.
    always @(posedge clk) begin
        bit popm;
        edge_cnt = edge_cnt + 32'd1;
        if (rst) begin
            fifo_m.delete();
            ovf_m    = 1'b0;
            cyc_base = '0;
            cyc_edge = edge_cnt;
        end else begin
            popm = (fifo_m.size() != 0) && tx_ready;
            if (popm) void'(fifo_m.pop_front());
            if (mem_write) begin
                if (in_ram(mem_addr)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (byte_en[i]) mem_m[widx(mem_addr)][8*i +: 8] = mem_wdata[8*i +: 8];
                    end
                end else if (mem_addr == MBASE) begin
                    if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(mem_wdata[7:0]);
                    else ovf_m = 1'b1;
                end else if (mem_addr == MBASE + 32'h4) begin
                    ovf_m = 1'b0;
                end else if (mem_addr == MBASE + 32'h8) begin
                    cyc_base = mem_wdata;
                    cyc_edge = edge_cnt;
                end
            end
        end
    end

    // Bus monitor: a response is presented in any request cycle with oLock low.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (mem_read || mem_write) begin
                if (lock) begin
                    mon_waits++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: addr=%h got data=%h with no expected entry", mem_addr, rdata);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL read_data addr=%h: got %h expected %h", e.addr, rdata, e.rdata);
                    end
                    checks++;
                    if (berr !== e.berr) begin
                        errors++;
                        $display("FAIL bus_error addr=%h: got %b expected %b", e.addr, berr, e.berr);
                    end
                    checks++;
                    if (mon_waits != int'(e.waits)) begin
                        errors++;
                        $display("FAIL lock_cycles addr=%h: got %0d expected %0d", e.addr, mon_waits, e.waits);
                    end
                    mon_waits = 0;
                end
            end else begin
                checks++;
                if (rdata !== 32'h0 || berr !== 1'b0 || lock !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got data=%h berr=%b lock=%b expected 0/0/0", rdata, berr, lock);
                end
            end
        end
    end

    // TX monitor: the head byte must match the oldest byte the model holds.
    always @(negedge clk) begin
        if (tx_mon_en && !rst) begin
            checks++;
            if (tx_valid !== (fifo_m.size() != 0)) begin
                errors++;
                $display("FAIL tx_valid: got %b expected %b", tx_valid, fifo_m.size() != 0);
            end else if (fifo_m.size() != 0) begin
                checks++;
                if (tx_data !== fifo_m[0]) begin
                    errors++;
                    $display("FAIL tx_data: got %h expected %h", tx_data, fifo_m[0]);
                end
            end
        end
    end

    // Issues one request (called #1 after a rising edge) and holds it until oLock drops.
    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
        bit lk;
        int n;
        exp_q.push_back(model_expect(rd, wr, a));
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        byte_en   = be;
        n = 0;
        do begin
            @(negedge clk);
            lk = lock;
            @(posedge clk);
            #1;
            n++;
        end while (lk && n < 5);
        if (lk) begin
            checks++;
            errors++;
            $display("FAIL lock_timeout addr=%h: oLock still high after %0d cycles, expected release", a, n);
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ram_addr();
        int w;
        w = $urandom_range(0, 16);
        if (w == 16) w = RAM_WORDS - 1;
        return DBASE + 32'(4 * w) + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_unmapped();
        logic [31:0] bad [4];
        bad[0] = 32'h0000_0000;
        bad[1] = DBASE - 32'h4;
        bad[2] = DBASE + 32'(4 * RAM_WORDS);
        bad[3] = MBASE + 32'hC;
        return bad[$urandom_range(0, 3)];
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (lock !== 1'b0 || rdata !== 32'h0 || berr !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs: got lock=%b data=%h berr=%b txv=%b txd=%h expected all 0",
                     lock, rdata, berr, tx_valid, tx_data);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.state);
        end
        @(posedge clk);
        #1;
        mon_en    = 1'b1;
        tx_mon_en = 1'b1;

        // Cycle counter from reset, then full-word store / load round trip
        req(1'b1, 1'b0, MBASE + 32'h8, '0, 4'h0);
        req(1'b0, 1'b1, 32'h1001_0010, 32'hDEADBEEF, 4'hF);
        req(1'b1, 1'b0, 32'h1001_0010, '0, 4'h0);
        req(1'b1, 1'b0, 32'h1001_0010, '0, 4'h0);

        // Single-lane merge into an existing word
        req(1'b0, 1'b1, 32'h1001_0020, 32'h1122_3344, 4'hF);
        req(1'b0, 1'b1, 32'h1001_0020, 32'h0000_AA00, 4'b0010);
        req(1'b1, 1'b0, 32'h1001_0020, '0, 4'h0);

        // Overflow: nine pushes into an eight-deep FIFO, drain, clear
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) req(1'b0, 1'b1, MBASE, 32'(i), 4'hF);
        req(1'b1, 1'b0, MBASE + 32'h4, '0, 4'h0);
        tx_ready = 1'b1;
        idle(10);
        req(1'b1, 1'b0, MBASE + 32'h4, '0, 4'h0);
        req(1'b0, 1'b1, MBASE + 32'h4, '0, 4'hF);
        req(1'b1, 1'b0, MBASE + 32'h4, '0, 4'h0);
        req(1'b1, 1'b0, MBASE, '0, 4'h0);

        // Push into a full FIFO while popping
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) req(1'b0, 1'b1, MBASE, 32'h40 + 32'(i), 4'hF);
        tx_ready = 1'b1;
        req(1'b0, 1'b1, MBASE, 32'hA5, 4'hF);
        tx_ready = 1'b0;
        req(1'b1, 1'b0, MBASE + 32'h4, '0, 4'h0);
        tx_ready = 1'b1;
        idle(10);
        tx_ready = 1'b0;

        // Counter load and wrap
        req(1'b0, 1'b1, MBASE + 32'h8, 32'hFFFF_FFFE, 4'hF);
        idle(1);
        req(1'b1, 1'b0, MBASE + 32'h8, '0, 4'h0);
        req(1'b1, 1'b0, MBASE + 32'h8, '0, 4'h0);

        // Unmapped and conflicting strobes
        req(1'b1, 1'b0, 32'h0000_0000, '0, 4'h0);
        req(1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF);
        req(1'b1, 1'b1, 32'h1001_0030, 32'h0BAD_F00D, 4'hF);
        req(1'b1, 1'b0, 32'h1001_0030, '0, 4'h0);
        req(1'b1, 1'b0, DBASE + 32'(4 * RAM_WORDS), '0, 4'h0);

        // Seed every RAM word used by the random phase
        for (int w = 0; w < 16; w++) req(1'b0, 1'b1, DBASE + 32'(4 * w), $urandom, 4'hF);
        req(1'b0, 1'b1, DBASE + 32'(4 * (RAM_WORDS - 1)), $urandom, 4'hF);

        for (int n = 0; n < 400; n++) begin
            int k;
            k = $urandom_range(0, 9);
            tx_ready = 1'($urandom_range(0, 1));
            case (k)
                0, 1: req(1'b0, 1'b1, rand_ram_addr(), $urandom, 4'($urandom_range(0, 15)));
                2, 3: req(1'b1, 1'b0, rand_ram_addr(), '0, 4'h0);
                4:    req(1'b0, 1'b1, MBASE, $urandom, 4'hF);
                5:    req(1'b1, 1'b0, MBASE + 32'h4, '0, 4'h0);
                6:    req(1'b0, 1'b1, MBASE + 32'h4, $urandom, 4'hF);
                7: begin
                    if ($urandom_range(0, 4) == 0) req(1'b0, 1'b1, MBASE + 32'h8, $urandom, 4'hF);
                    else req(1'b1, 1'b0, MBASE + 32'h8, '0, 4'h0);
                end
                8:    req(1'($urandom_range(0, 1)), 1'b1, rand_unmapped(), $urandom, 4'hF);
                default: req(1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? rand_ram_addr() : MBASE,
                             $urandom, 4'($urandom_range(0, 15)));
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        // Reset during a RAM load's wait cycle
        mon_en    = 1'b0;
        mon_waits = 0;
        mem_read  = 1'b1;
        mem_addr  = 32'h1001_0010;
        @(negedge clk);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("FAIL lock_before_reset: got %b expected 1", lock);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (lock !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_load: got lock=%b state=%0d expected lock=0 state=IDLE", lock, dut.state);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        req(1'b1, 1'b0, 32'h1001_0010, '0, 4'h0);
        req(1'b1, 1'b0, MBASE + 32'h4, '0, 4'h0);
        idle(2);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
